// File: rtl/stack_sequencer.sv
// Multi-register push/pop sequencer: walks STACK_* masks, issues one stack bus
// cycle per set bit, tracks SP, writes popped values back and reports the final SP.
module stack_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  input  logic [15:0] reg_rdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [3:0]  reg_sel,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_data,
  output logic        sp_we,
  output logic [15:0] sp_out,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StPush, StPop, StFin} state_e;

  localparam logic [3:0] SpItem = 4'd4;

  state_e      state_q, state_d;
  logic [15:0] push_mask_q, push_mask_d;
  logic [15:0] pop_mask_q, pop_mask_d;
  logic [15:0] sp_cur_q, sp_cur_d;
  logic [15:0] sp_lat_q, sp_lat_d;

  logic [3:0]  push_idx;
  logic [3:0]  pop_idx;
  logic [15:0] push_left;
  logic [15:0] pop_left;
  logic        in_push;
  logic        in_pop;
  logic        in_fin;

  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] highest_bit(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Item selection and bus/writeback outputs decoded from the registered state.
  always_comb begin
    in_push   = (state_q == StPush);
    in_pop    = (state_q == StPop);
    in_fin    = (state_q == StFin);
    push_idx  = lowest_bit(push_mask_q);
    pop_idx   = highest_bit(pop_mask_q);
    push_left = push_mask_q & ~(16'd1 << push_idx);
    pop_left  = pop_mask_q & ~(16'd1 << pop_idx);

    busy      = (state_q != StIdle);
    mem_req   = in_push | in_pop;
    mem_we    = in_push;
    mem_addr  = in_push ? (sp_cur_q - 16'd2) : (in_pop ? sp_cur_q : 16'd0);
    // SP itself is pushed as it stood at start, not as the register file shows it.
    mem_wdata = in_push ? ((push_idx == SpItem) ? sp_lat_q : reg_rdata) : 16'd0;
    reg_sel   = in_push ? push_idx : (in_pop ? pop_idx : 4'd0);
    // A popped SP slot is discarded; SP is rebuilt from the running count instead.
    wr_en     = in_pop & mem_ack & (pop_idx != SpItem);
    wr_sel    = wr_en ? pop_idx : 4'd0;
    wr_data   = wr_en ? mem_rdata : 16'd0;
    done      = in_fin;
    sp_we     = in_fin;
    sp_out    = in_fin ? sp_cur_q : 16'd0;
  end

  // Next-state: latch on start, consume one mask bit per acknowledged bus cycle.
  always_comb begin
    state_d     = state_q;
    push_mask_d = push_mask_q;
    pop_mask_d  = pop_mask_q;
    sp_cur_d    = sp_cur_q;
    sp_lat_d    = sp_lat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          push_mask_d = push_mask;
          pop_mask_d  = pop_mask;
          sp_cur_d    = sp_in;
          sp_lat_d    = sp_in;
          if (push_mask != 16'd0)     state_d = StPush;
          else if (pop_mask != 16'd0) state_d = StPop;
          else                        state_d = StFin;
        end
      end
      StPush: begin
        if (mem_ack) begin
          sp_cur_d    = sp_cur_q - 16'd2;
          push_mask_d = push_left;
          if (push_left == 16'd0) state_d = (pop_mask_q != 16'd0) ? StPop : StFin;
        end
      end
      StPop: begin
        if (mem_ack) begin
          sp_cur_d   = sp_cur_q + 16'd2;
          pop_mask_d = pop_left;
          if (pop_left == 16'd0) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops straight to idle, abandoning any sequence in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      push_mask_q <= 16'd0;
      pop_mask_q  <= 16'd0;
      sp_cur_q    <= 16'd0;
      sp_lat_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      push_mask_q <= push_mask_d;
      pop_mask_q  <= pop_mask_d;
      sp_cur_q    <= sp_cur_d;
      sp_lat_q    <= sp_lat_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: expected bus/writeback/finish events are
// queued by the stimulus; a monitor pops and compares as the DUT presents them.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] push_mask, pop_mask, sp_in, reg_rdata, mem_rdata;
  logic        mem_ack, ack_r, stray_ack;
  logic        busy, mem_req, mem_we, wr_en, sp_we, done;
  logic [15:0] mem_addr, mem_wdata, wr_data, sp_out;
  logic [3:0]  reg_sel, wr_sel;

  int total = 0;
  int bad = 0;
  int ack_wait = 0;

  typedef struct {
    int          kind;  // 0 bus cycle, 1 writeback, 2 finish
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  sel;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // Register file and memory models.
  assign reg_rdata = (reg_sel == 4'd4) ? 16'hBEEF : (16'h1100 + {12'h000, reg_sel});
  assign mem_rdata = mem_addr ^ 16'h5A5A;
  assign mem_ack   = ack_r | stray_ack;

  stack_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .push_mask (push_mask),
    .pop_mask  (pop_mask),
    .sp_in     (sp_in),
    .reg_rdata (reg_rdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .reg_sel   (reg_sel),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .sp_we     (sp_we),
    .sp_out    (sp_out),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [3:0] s);
    exp_t e;
    e.kind = 0; e.we = we; e.addr = a; e.data = d; e.sel = s;
    q.push_back(e);
  endtask

  task automatic exp_wr(input logic [3:0] s, input logic [15:0] d);
    exp_t e;
    e.kind = 1; e.we = 1'b0; e.addr = 16'd0; e.data = d; e.sel = s;
    q.push_back(e);
  endtask

  task automatic exp_fin(input logic [15:0] sp);
    exp_t e;
    e.kind = 2; e.we = 1'b0; e.addr = 16'd0; e.data = sp; e.sel = 4'd0;
    q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic [3:0] s);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h sel=%0d required none",
               kind, a, d, s);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_we", {31'd0, we}, {31'd0, e.we});
      chk("event_addr", {16'd0, a}, {16'd0, e.addr});
      chk("event_data", {16'd0, d}, {16'd0, e.data});
      chk("event_sel", {28'd0, s}, {28'd0, e.sel});
    end
  endtask

  // Memory responder: acknowledges after ack_wait idle request cycles.
  initial begin
    int wcnt;
    wcnt  = 0;
    ack_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && mem_req) begin
        if (wcnt >= ack_wait) begin
          ack_r = 1'b1;
          wcnt  = 0;
        end else begin
          ack_r = 1'b0;
          wcnt++;
        end
      end else begin
        ack_r = 1'b0;
        wcnt  = 0;
      end
    end
  end

  // Monitor: request stability during waits, then scoreboard events.
  initial begin
    bit          held;
    logic        p_we;
    logic [15:0] p_addr, p_wdata;
    logic [3:0]  p_sel;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        held = 1'b0;
      end else begin
        if (mem_req) begin
          if (held) begin
            chk("stable_we", {31'd0, mem_we}, {31'd0, p_we});
            chk("stable_addr", {16'd0, mem_addr}, {16'd0, p_addr});
            chk("stable_wdata", {16'd0, mem_wdata}, {16'd0, p_wdata});
            chk("stable_sel", {28'd0, reg_sel}, {28'd0, p_sel});
          end
          if (mem_ack) begin
            sb_pop(0, mem_we, mem_addr, mem_we ? mem_wdata : 16'd0, reg_sel);
            held = 1'b0;
          end else begin
            p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_sel = reg_sel;
            held = 1'b1;
          end
        end else begin
          held = 1'b0;
        end
        if (wr_en) sb_pop(1, 1'b0, 16'd0, wr_data, wr_sel);
        if (done || sp_we) begin
          chk("fin_done", {31'd0, done}, 32'd1);
          chk("fin_sp_we", {31'd0, sp_we}, 32'd1);
          sb_pop(2, 1'b0, 16'd0, sp_out, 4'd0);
        end
      end
    end
  end

  // Issue one start and wait (bounded) for done; optionally pulse start while busy.
  task automatic run(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp,
                     input int waits, input int exp_cyc, input bit poke);
    int cyc;
    bit got;
    ack_wait = waits;
    @(negedge clk);
    push_mask = pm; pop_mask = qm; sp_in = sp; start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && (cyc == 2 || cyc == 6)) begin
        start = 1'b1; push_mask = 16'hFFFF; pop_mask = 16'hFFFF; sp_in = 16'hDEAD;
      end
      if (poke && (cyc == 3 || cyc == 7)) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_latency", cyc, exp_cyc);
    @(negedge clk);
    #1;
    chk("idle_after_fin", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stray_ack = 1'b0;
    push_mask = 16'd0; pop_mask = 16'd0; sp_in = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {26'd0, busy, mem_req, mem_we, wr_en, sp_we, done}, 32'd0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_sel", {24'd0, reg_sel, wr_sel}, 32'd0);
    chk("rst_wr_sp", {wr_data, sp_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // PUSH R: items 0..7 downward from 0x1000; SP item writes the latched 0x1000.
    for (int i = 0; i < 8; i++)
      exp_bus(1'b1, 16'h0FFE - 16'(2 * i), (i == 4) ? 16'h1000 : 16'h1100 + 16'(i), 4'(i));
    exp_fin(16'h0FF0);
    run(16'h00FF, 16'h0000, 16'h1000, 0, 9, 1'b0);

    // POP R: items 7..0 upward from 0x0FF0; item 4 read but not written back.
    for (int i = 0; i < 8; i++) begin
      exp_bus(1'b0, 16'h0FF0 + 16'(2 * i), 16'd0, 4'(7 - i));
      if (i != 3) exp_wr(4'(7 - i), (16'h0FF0 + 16'(2 * i)) ^ 16'h5A5A);
    end
    exp_fin(16'h1000);
    run(16'h0000, 16'h00FF, 16'h0FF0, 0, 9, 1'b0);

    // Interrupt frame with 3-cycle ack delay, wrapping below zero, start poked while busy.
    exp_bus(1'b1, 16'h0000, 16'h1109, 4'd9);
    exp_bus(1'b1, 16'hFFFE, 16'h110A, 4'd10);
    exp_bus(1'b1, 16'hFFFC, 16'h110D, 4'd13);
    exp_fin(16'hFFFC);
    run(16'h2600, 16'h0000, 16'h0002, 3, 13, 1'b1);

    // Empty masks: finish one cycle after start, no bus traffic.
    exp_fin(16'h1234);
    run(16'h0000, 16'h0000, 16'h1234, 0, 1, 1'b0);

    // Combined: push item 0 then pop item 1 from the same slot.
    exp_bus(1'b1, 16'h1FFE, 16'h1100, 4'd0);
    exp_bus(1'b0, 16'h1FFE, 16'd0, 4'd1);
    exp_wr(4'd1, 16'h45A4);
    exp_fin(16'h2000);
    run(16'h0001, 16'h0002, 16'h2000, 0, 3, 1'b0);

    // Pop wrapping 0xFFFE -> 0x0000.
    exp_bus(1'b0, 16'hFFFE, 16'd0, 4'd2);
    exp_wr(4'd2, 16'hA5A4);
    exp_fin(16'h0000);
    run(16'h0000, 16'h0004, 16'hFFFE, 0, 2, 1'b0);

    // Reset during the second push wait: only the first push completes.
    ack_wait = 3;
    exp_bus(1'b1, 16'h02FE, 16'h1100, 4'd0);
    @(negedge clk);
    push_mask = 16'h0003; pop_mask = 16'h0000; sp_in = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_drops_req", {29'd0, mem_req, busy, mem_we}, 32'd0);
    chk("reset_no_fin", {30'd0, done, sp_we}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_ack_ignored", {29'd0, busy, mem_req, wr_en}, 32'd0);
    stray_ack = 1'b0;

    // Normal run after reset: items 0 and 4.
    exp_bus(1'b1, 16'h00FE, 16'h1100, 4'd0);
    exp_bus(1'b1, 16'h00FC, 16'h0100, 4'd4);
    exp_fin(16'h00FC);
    run(16'h0011, 16'h0000, 16'h0100, 0, 3, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
